axi4_ddr_arbiter: RTL and testbench
===================================

Name: axi4_ddr_arbiter

Overview:
- N-slot AXI4 arbiter in front of the DDR master port; merges the cache-wrapper AXI master and the host PCIS master into one AXI4 master.
- AW and AR are arbitrated independently, round-robin.
- Write data is ordered by a granted-slot FIFO.
- Responses are routed back by slot bits carried in the upper AXI ID bits.

Parameters:
- slot_num_p, 2, number of upstream AXI4 masters; must be ≥2.
- id_width_p, 6, AXI ID width on every port.
- addr_width_p, 64, AXI address width.
- data_width_p, 512, AXI data width.
- wr_fifo_els_p, 4, depth of the write-order FIFO, i.e. maximum accepted AWs whose W burst has not completed.
- slot_lg_lp (localparam), `$clog2(slot_num_p)`; must be < id_width_p.

Ports:
- clk_i, input, 1, clock.
- resetn_i, input, 1, reset: asynchronous, active-low.
- s_axi_mux_i, input, slot_num_p*mosi_w, packed AXI4 mosi buses (bsg_axi_bus_pkg layout, 1 bus each); slot 0 in the LSBs.
- s_axi_mux_o, output, slot_num_p*miso_w, packed AXI4 miso buses, same ordering.
- m_axi_bus_o, output, mosi_w, AXI4 mosi bus toward DDR.
- m_axi_bus_i, input, miso_w, AXI4 miso bus from DDR.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all m-side valids and all s-side readies/valids = 0;
  - both RR pointers select slot 0 as highest priority;
  - AW/AR lock flags cleared; write FIFO empty.
- Any in-flight transaction is dropped on reset; upstream masters are reset by the same tree.
- ID rules:
  - Slave-issued IDs must have the top slot_lg_lp bits = 0.
  - m awid/arid = {slot index, s id[id_width_p-slot_lg_lp-1:0]}.
  - bid/rid top bits select the destination slot and are zeroed on the returned ID.
  - Returned responses are combinational: destination bvalid/rvalid = m valid; m bready/rready = destination's ready; all other slots see valid=0.
- AW channel:
  - When not locked, the winner is the first awvalid slot at or after the RR pointer; its payload and awvalid are driven to m combinationally.
  - If m_awready=0 that cycle, aw_lock_r=1 and aw_grant_r=winner; the grant holds until the handshake (AXI valid stability).
  - On handshake: the RR pointer moves to winner+1 (mod slot_num_p), the lock clears, and the slot index is pushed into the write FIFO.
  - m_awvalid is forced 0 and all s awready=0 while the FIFO is full; push only when not full, with no full-bypass on same-cycle pop.
  - A locked grant is not revoked when the FIFO fills after the lock, because a push is only needed at handshake and lock implies not-full.
- W channel:
  - Head slot = FIFO head.
  - When FIFO empty: m_wvalid=0 and all s wready=0.
  - Otherwise W payload and wvalid come from the head slot, and only the head slot sees wready=m_wready.
  - Pop on a wvalid&wready&wlast handshake.
  - No bypass: a W beat is forwarded at the earliest the cycle after its AW handshake.
  - W presented before its AW simply waits.
  - Simultaneous push and pop is legal; occupancy is unchanged.
- AR channel: same RR and lock scheme as AW, with its own pointer and lock; no FIFO and no backpressure beyond m_arready.
- Pass-through: region/qos/cache/prot/lock/burst/len/size fields are carried unchanged from the granted slot.
- Latency: zero added cycles on AW/AR/B/R; ≥1 cycle from an AW handshake to the first W beat.
- Fairness: with all slots requesting continuously, grants rotate strictly 0,1,…,N-1,0.

Test Plan:
- Reset released with idle inputs: all outputs hold 0 valids/readies; assert resetn_i low mid-burst → m_wvalid, m_awvalid and the FIFO count drop to 0 asynchronously within the same cycle.
- Both slots hold awvalid every cycle, m_awready=1:
  - expected grant order 0,1,0,1;
  - slot1 awid=5 → m_awid=6'b100101;
  - bid=6'b100101 → s1 bvalid with bid=5, s0 bvalid=0.
- Slot0 AW (len=3) then slot1 AW (len=0): W beats forwarded are s0×4 (wlast on beat 4), then s1×1; s1 wready stays 0 until s0's wlast handshake.
- wr_fifo_els_p=4 with m_wready=0: 4 AWs are accepted and the 5th awvalid sees awready=0; one wlast handshake → the 5th is accepted the next cycle.
- Slot1 arvalid with m_arready=0 for 3 cycles while slot0 raises arvalid: m_ar* stays on slot1 (locked); after the handshake slot0 is granted; rid top bit routes R beats to the correct slot, and rlast is passed through.

Source files
------------

// File: rtl/axi4_ddr_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_ddr_arbiter
//
// Merges slot_num_p upstream AXI4 masters onto the single DDR master port.
//   * AW and AR are arbitrated independently, round-robin, with a grant lock
//     that keeps a presented request stable until its handshake.
//   * Write data is ordered by a FIFO of granted AW slot indices. A W beat is
//     forwarded no earlier than the cycle after its AW handshake.
//   * The slot index is carried in the top slot_lg_lp bits of the downstream
//     ID. B/R responses are steered back by those bits, which are zeroed on
//     the ID returned to the slot.
//
// Ports
//   clk_i        clock
//   resetn_i     asynchronous active-low reset
//   s_axi_mux_i  slot_num_p packed mosi buses, slot 0 in the LSBs
//   s_axi_mux_o  slot_num_p packed miso buses, same ordering
//   m_axi_bus_o  mosi bus toward DDR
//   m_axi_bus_i  miso bus from DDR
//
// Bus layout, MSB first (mosi_s / miso_s below):
//   mosi = { aw{id,addr,len,size,burst,lock,cache,prot,qos,region,valid},
//            w{data,strb,last,valid}, bready,
//            ar{id,addr,len,size,burst,lock,cache,prot,qos,region,valid},
//            rready }
//   miso = { awready, wready, b{id,resp,valid}, arready,
//            r{id,data,resp,last,valid} }
//
// slot_num_p must be >= 2 and slot_lg_lp must be < id_width_p. Slot-issued
// IDs must have their top slot_lg_lp bits at zero.
// ---------------------------------------------------------------------------
module axi4_ddr_arbiter #(
  parameter int   slot_num_p    = 2,
  parameter int   id_width_p    = 6,
  parameter int   addr_width_p  = 64,
  parameter int   data_width_p  = 512,
  parameter int   wr_fifo_els_p = 4,
  localparam int  slot_lg_lp    = $clog2(slot_num_p),
  localparam int  mosi_w_lp     = 2*id_width_p + 2*addr_width_p + data_width_p
                                  + data_width_p/8 + 64,
  localparam int  miso_w_lp     = 2*id_width_p + data_width_p + 10
) (
  input  logic                             clk_i,
  input  logic                             resetn_i,
  input  logic [slot_num_p*mosi_w_lp-1:0]  s_axi_mux_i,
  output logic [slot_num_p*miso_w_lp-1:0]  s_axi_mux_o,
  output logic [mosi_w_lp-1:0]             m_axi_bus_o,
  input  logic [miso_w_lp-1:0]             m_axi_bus_i
);

  localparam int id_lo_w_lp    = id_width_p - slot_lg_lp;
  localparam int fifo_ptr_w_lp = (wr_fifo_els_p > 1) ? $clog2(wr_fifo_els_p) : 1;
  localparam int fifo_cnt_w_lp = $clog2(wr_fifo_els_p + 1);

  typedef logic [slot_lg_lp-1:0] slot_t;

  typedef struct packed {
    logic [id_width_p-1:0]   id;
    logic [addr_width_p-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic                    valid;
  } ax_s;

  typedef struct packed {
    logic [data_width_p-1:0]   data;
    logic [data_width_p/8-1:0] strb;
    logic                      last;
    logic                      valid;
  } w_s;

  typedef struct packed {
    logic [id_width_p-1:0] id;
    logic [1:0]            resp;
    logic                  valid;
  } b_s;

  typedef struct packed {
    logic [id_width_p-1:0]   id;
    logic [data_width_p-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic                    valid;
  } r_s;

  typedef struct packed {
    ax_s  aw;
    w_s   w;
    logic bready;
    ax_s  ar;
    logic rready;
  } mosi_s;

  typedef struct packed {
    logic awready;
    logic wready;
    b_s   b;
    logic arready;
    r_s   r;
  } miso_s;

  mosi_s [slot_num_p-1:0] s_mosi;
  miso_s [slot_num_p-1:0] s_miso;
  mosi_s                  m_mosi;
  miso_s                  m_miso;

  assign s_mosi      = s_axi_mux_i;
  assign s_axi_mux_o = s_miso;
  assign m_axi_bus_o = m_mosi;
  assign m_miso      = m_axi_bus_i;

  // First requesting slot at or after ptr, wrapping around.
  function automatic slot_t rr_pick(input logic [slot_num_p-1:0] req, input slot_t ptr);
    slot_t pick;
    logic  found;
    int    idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < slot_num_p; i++) begin
      idx = (int'(ptr) + i) % slot_num_p;
      if (!found && req[idx]) begin
        pick  = slot_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic slot_t rr_next(input slot_t s);
    return slot_t'((int'(s) + 1) % slot_num_p);
  endfunction

  function automatic logic [fifo_ptr_w_lp-1:0] ptr_inc(input logic [fifo_ptr_w_lp-1:0] p);
    return (p == fifo_ptr_w_lp'(wr_fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration state
  slot_t aw_ptr_q, aw_ptr_d, aw_grant_q, aw_grant_d;
  slot_t ar_ptr_q, ar_ptr_d, ar_grant_q, ar_grant_d;
  logic  aw_lock_q, aw_lock_d, ar_lock_q, ar_lock_d;

  // Write-order FIFO
  slot_t                    fifo_mem_q [wr_fifo_els_p];
  logic [fifo_ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [fifo_cnt_w_lp-1:0] fifo_cnt_q, fifo_cnt_d;
  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic [slot_num_p-1:0] aw_req, ar_req;
  slot_t                 aw_sel, ar_sel, w_head, b_dst, r_dst;
  logic                  aw_valid, aw_hs, ar_valid, ar_hs, w_valid;
  logic                  unused_id_bits;

  assign fifo_full  = (fifo_cnt_q == fifo_cnt_w_lp'(wr_fifo_els_p));
  assign fifo_empty = (fifo_cnt_q == '0);

  always_comb begin
    aw_req         = '0;
    ar_req         = '0;
    unused_id_bits = 1'b0;
    for (int i = 0; i < slot_num_p; i++) begin
      aw_req[i] = s_mosi[i].aw.valid;
      ar_req[i] = s_mosi[i].ar.valid;
      // Slot IDs arrive with zeroed top bits; those bits are replaced below.
      unused_id_bits ^= ^{s_mosi[i].aw.id[id_width_p-1 -: slot_lg_lp],
                          s_mosi[i].ar.id[id_width_p-1 -: slot_lg_lp]};
    end
  end

  // Datapath muxing and routing. Valids and readies are qualified with
  // resetn_i so they fall with the asynchronous reset, not at the next edge.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through this block can leave a signal unassigned and infer a latch.
    m_mosi = '0;
    s_miso = '0;

    // AW: a held lock overrides the round-robin pick.
    aw_sel          = aw_lock_q ? aw_grant_q : rr_pick(aw_req, aw_ptr_q);
    aw_valid        = resetn_i & ~fifo_full & s_mosi[aw_sel].aw.valid;
    aw_hs           = aw_valid & m_miso.awready;
    m_mosi.aw       = s_mosi[aw_sel].aw;
    m_mosi.aw.id    = {aw_sel, s_mosi[aw_sel].aw.id[id_lo_w_lp-1:0]};
    m_mosi.aw.valid = aw_valid;
    s_miso[aw_sel].awready = aw_hs;

    // AR: same scheme, no FIFO backpressure.
    ar_sel          = ar_lock_q ? ar_grant_q : rr_pick(ar_req, ar_ptr_q);
    ar_valid        = resetn_i & s_mosi[ar_sel].ar.valid;
    ar_hs           = ar_valid & m_miso.arready;
    m_mosi.ar       = s_mosi[ar_sel].ar;
    m_mosi.ar.id    = {ar_sel, s_mosi[ar_sel].ar.id[id_lo_w_lp-1:0]};
    m_mosi.ar.valid = ar_valid;
    s_miso[ar_sel].arready = ar_hs;

    // W: only the FIFO head slot may move data.
    w_head         = fifo_empty ? slot_t'(0) : fifo_mem_q[rd_ptr_q];
    w_valid        = resetn_i & ~fifo_empty & s_mosi[w_head].w.valid;
    m_mosi.w       = s_mosi[w_head].w;
    m_mosi.w.valid = w_valid;
    s_miso[w_head].wready = resetn_i & ~fifo_empty & m_miso.wready;
    fifo_pop       = w_valid & m_miso.wready & s_mosi[w_head].w.last;

    // B / R: steer by the slot bits in the returned ID.
    b_dst = m_miso.b.id[id_width_p-1 -: slot_lg_lp];
    r_dst = m_miso.r.id[id_width_p-1 -: slot_lg_lp];
    for (int i = 0; i < slot_num_p; i++) begin
      s_miso[i].b       = m_miso.b;
      s_miso[i].b.id    = {{slot_lg_lp{1'b0}}, m_miso.b.id[id_lo_w_lp-1:0]};
      s_miso[i].b.valid = resetn_i & m_miso.b.valid & (b_dst == slot_t'(i));
      s_miso[i].r       = m_miso.r;
      s_miso[i].r.id    = {{slot_lg_lp{1'b0}}, m_miso.r.id[id_lo_w_lp-1:0]};
      s_miso[i].r.valid = resetn_i & m_miso.r.valid & (r_dst == slot_t'(i));
      if (b_dst == slot_t'(i)) m_mosi.bready = resetn_i & s_mosi[i].bready;
      if (r_dst == slot_t'(i)) m_mosi.rready = resetn_i & s_mosi[i].rready;
    end
  end

  // Next-state: pointer advance, lock, FIFO bookkeeping.
  always_comb begin
    aw_ptr_d   = aw_ptr_q;
    aw_lock_d  = aw_lock_q;
    aw_grant_d = aw_grant_q;
    ar_ptr_d   = ar_ptr_q;
    ar_lock_d  = ar_lock_q;
    ar_grant_d = ar_grant_q;

    if (aw_hs) begin
      aw_ptr_d  = rr_next(aw_sel);
      aw_lock_d = 1'b0;
    end else if (aw_valid) begin
      aw_lock_d  = 1'b1;
      aw_grant_d = aw_sel;
    end

    if (ar_hs) begin
      ar_ptr_d  = rr_next(ar_sel);
      ar_lock_d = 1'b0;
    end else if (ar_valid) begin
      ar_lock_d  = 1'b1;
      ar_grant_d = ar_sel;
    end

    // aw_hs already implies not full, so no full-bypass on a same-cycle pop.
    fifo_push = aw_hs;
    wr_ptr_d  = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = fifo_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      aw_ptr_q   <= '0;
      aw_grant_q <= '0;
      aw_lock_q  <= 1'b0;
      ar_ptr_q   <= '0;
      ar_grant_q <= '0;
      ar_lock_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      aw_ptr_q   <= aw_ptr_d;
      aw_grant_q <= aw_grant_d;
      aw_lock_q  <= aw_lock_d;
      ar_ptr_q   <= ar_ptr_d;
      ar_grant_q <= ar_grant_d;
      ar_lock_q  <= ar_lock_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // NOTE: the FIFO storage has no reset; entries are only read while the
  // reset-cleared count says they hold valid data.
  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= aw_sel;
  end

endmodule

// File: tb/tb_axi4_ddr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_ddr_arbiter
//
// Directed bench for axi4_ddr_arbiter with two slots, 6-bit IDs, 32-bit
// addresses, 64-bit data and a 4-deep write-order FIFO. Inputs change one
// time unit after the rising edge; outputs are checked two units after it.
// ---------------------------------------------------------------------------
module tb_axi4_ddr_arbiter;

  localparam int ID   = 6;
  localparam int ADDR = 32;
  localparam int DATA = 64;

  typedef struct packed {
    logic [ID-1:0]   id;
    logic [ADDR-1:0] addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic            lock;
    logic [3:0]      cache;
    logic [2:0]      prot;
    logic [3:0]      qos;
    logic [3:0]      region;
    logic            valid;
  } ax_s;

  typedef struct packed {
    logic [DATA-1:0]   data;
    logic [DATA/8-1:0] strb;
    logic              last;
    logic              valid;
  } w_s;

  typedef struct packed {
    logic [ID-1:0] id;
    logic [1:0]    resp;
    logic          valid;
  } b_s;

  typedef struct packed {
    logic [ID-1:0]   id;
    logic [DATA-1:0] data;
    logic [1:0]      resp;
    logic            last;
    logic            valid;
  } r_s;

  typedef struct packed {
    ax_s  aw;
    w_s   w;
    logic bready;
    ax_s  ar;
    logic rready;
  } mosi_s;

  typedef struct packed {
    logic awready;
    logic wready;
    b_s   b;
    logic arready;
    r_s   r;
  } miso_s;

  logic        clk;
  logic        resetn;
  mosi_s [1:0] s_mosi;
  miso_s [1:0] s_miso;
  mosi_s       m_mosi;
  miso_s       m_miso;

  int total = 0;
  int bad   = 0;

  axi4_ddr_arbiter #(
    .slot_num_p   (2),
    .id_width_p   (ID),
    .addr_width_p (ADDR),
    .data_width_p (DATA),
    .wr_fifo_els_p(4)
  ) dut (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .s_axi_mux_i(s_mosi),
    .s_axi_mux_o(s_miso),
    .m_axi_bus_o(m_mosi),
    .m_axi_bus_i(m_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    s_mosi = '0;
    m_miso = '0;

    // ---------------- reset state ----------------
    #3;
    check("rst_m_awvalid", 64'(m_mosi.aw.valid), 64'h0);
    check("rst_m_wvalid",  64'(m_mosi.w.valid),  64'h0);
    check("rst_m_arvalid", 64'(m_mosi.ar.valid), 64'h0);
    check("rst_s_out_any", 64'(|s_miso),         64'h0);

    @(negedge clk);
    resetn = 1'b1;
    m_miso.awready = 1'b1;
    m_miso.arready = 1'b1;
    m_miso.wready  = 1'b0;
    next_cycle();
    settle();
    check("idle_m_awvalid", 64'(m_mosi.aw.valid), 64'h0);
    check("idle_s0_awready", 64'(s_miso[0].awready), 64'h0);
    check("idle_s1_awready", 64'(s_miso[1].awready), 64'h0);
    check("idle_s0_wready",  64'(s_miso[0].wready),  64'h0);

    // ---------------- AW round robin, FIFO fills ----------------
    s_mosi[0].aw.id = 6'h03; s_mosi[0].aw.addr = 32'h100; s_mosi[0].aw.len = 8'd3;
    s_mosi[0].aw.valid = 1'b1;
    s_mosi[1].aw.id = 6'h05; s_mosi[1].aw.addr = 32'h200; s_mosi[1].aw.len = 8'd0;
    s_mosi[1].aw.valid = 1'b1;
    settle();
    check("c1_m_awid",    64'(m_mosi.aw.id),    64'h03);
    check("c1_m_awaddr",  64'(m_mosi.aw.addr),  64'h100);
    check("c1_m_awlen",   64'(m_mosi.aw.len),   64'h3);
    check("c1_s0_awready", 64'(s_miso[0].awready), 64'h1);
    check("c1_s1_awready", 64'(s_miso[1].awready), 64'h0);
    next_cycle(); settle();
    check("c2_m_awid",    64'(m_mosi.aw.id),    64'h25);
    check("c2_m_awaddr",  64'(m_mosi.aw.addr),  64'h200);
    check("c2_s1_awready", 64'(s_miso[1].awready), 64'h1);
    check("c2_s0_awready", 64'(s_miso[0].awready), 64'h0);
    next_cycle(); settle();
    check("c3_m_awid", 64'(m_mosi.aw.id), 64'h03);
    next_cycle(); settle();
    check("c4_m_awid", 64'(m_mosi.aw.id), 64'h25);
    next_cycle(); settle();
    // four AWs outstanding, no W yet: fifth request must stall
    check("full_m_awvalid",  64'(m_mosi.aw.valid),    64'h0);
    check("full_s0_awready", 64'(s_miso[0].awready),  64'h0);
    check("full_s1_awready", 64'(s_miso[1].awready),  64'h0);

    // ---------------- B routing ----------------
    m_miso.b.id = 6'h25; m_miso.b.valid = 1'b1;
    s_mosi[1].bready = 1'b1; s_mosi[0].bready = 1'b0;
    settle();
    check("b1_s1_bvalid", 64'(s_miso[1].b.valid), 64'h1);
    check("b1_s1_bid",    64'(s_miso[1].b.id),    64'h05);
    check("b1_s0_bvalid", 64'(s_miso[0].b.valid), 64'h0);
    check("b1_m_bready",  64'(m_mosi.bready),     64'h1);
    m_miso.b.id = 6'h03;
    settle();
    check("b0_s0_bvalid", 64'(s_miso[0].b.valid), 64'h1);
    check("b0_s0_bid",    64'(s_miso[0].b.id),    64'h03);
    check("b0_s1_bvalid", 64'(s_miso[1].b.valid), 64'h0);
    check("b0_m_bready",  64'(m_mosi.bready),     64'h0);
    m_miso.b.valid = 1'b0;

    // ---------------- W ordering: s0 x4 then s1 x1 ----------------
    s_mosi[1].w.data = 64'hB1; s_mosi[1].w.last = 1'b1; s_mosi[1].w.valid = 1'b1;
    s_mosi[0].w.data = 64'hA0; s_mosi[0].w.last = 1'b0; s_mosi[0].w.valid = 1'b1;
    m_miso.wready = 1'b1;
    settle();
    check("w0_m_wvalid",  64'(m_mosi.w.valid),   64'h1);
    check("w0_m_wdata",   64'(m_mosi.w.data),    64'hA0);
    check("w0_s0_wready", 64'(s_miso[0].wready), 64'h1);
    check("w0_s1_wready", 64'(s_miso[1].wready), 64'h0);
    next_cycle();
    s_mosi[0].w.data = 64'hA1;
    settle();
    check("w1_m_wdata",   64'(m_mosi.w.data),    64'hA1);
    check("w1_s1_wready", 64'(s_miso[1].wready), 64'h0);
    next_cycle();
    s_mosi[0].w.data = 64'hA2;
    next_cycle();
    s_mosi[0].w.data = 64'hA3; s_mosi[0].w.last = 1'b1;
    settle();
    check("w3_m_wlast",    64'(m_mosi.w.last),     64'h1);
    check("w3_s1_wready",  64'(s_miso[1].wready),  64'h0);
    check("w3_s0_awready", 64'(s_miso[0].awready), 64'h0);
    next_cycle();
    // wlast popped: fifth AW (slot 0) accepted while slot 1 pops in parallel
    s_mosi[0].w.valid = 1'b0;
    settle();
    check("c9_s0_awready", 64'(s_miso[0].awready), 64'h1);
    check("c9_m_awid",     64'(m_mosi.aw.id),      64'h03);
    check("c9_s1_wready",  64'(s_miso[1].wready),  64'h1);
    check("c9_m_wdata",    64'(m_mosi.w.data),     64'hB1);
    check("c9_s0_wready",  64'(s_miso[0].wready),  64'h0);
    next_cycle();

    // ---------------- drain remaining order 0,1,0 ----------------
    s_mosi[0].aw.valid = 1'b0; s_mosi[1].aw.valid = 1'b0;
    s_mosi[0].w.data = 64'hC0; s_mosi[0].w.last = 1'b1; s_mosi[0].w.valid = 1'b1;
    s_mosi[1].w.data = 64'hC1; s_mosi[1].w.last = 1'b1; s_mosi[1].w.valid = 1'b1;
    settle();
    check("d0_m_wdata",   64'(m_mosi.w.data),    64'hC0);
    check("d0_s1_wready", 64'(s_miso[1].wready), 64'h0);
    next_cycle(); settle();
    check("d1_m_wdata",   64'(m_mosi.w.data),    64'hC1);
    check("d1_s0_wready", 64'(s_miso[0].wready), 64'h0);
    next_cycle(); settle();
    check("d2_m_wdata",   64'(m_mosi.w.data),    64'hC0);
    next_cycle(); settle();
    check("empty_m_wvalid",  64'(m_mosi.w.valid),   64'h0);
    check("empty_s0_wready", 64'(s_miso[0].wready), 64'h0);
    check("empty_s1_wready", 64'(s_miso[1].wready), 64'h0);

    // ---------------- no W bypass on the AW handshake cycle ----------------
    s_mosi[1].w.valid = 1'b0;
    s_mosi[0].w.data = 64'hD0;
    s_mosi[0].aw.id = 6'h0A; s_mosi[0].aw.valid = 1'b1;
    settle();
    check("byp_m_awvalid", 64'(m_mosi.aw.valid),  64'h1);
    check("byp_m_awid",    64'(m_mosi.aw.id),     64'h0A);
    check("byp_m_wvalid",  64'(m_mosi.w.valid),   64'h0);
    check("byp_s0_wready", 64'(s_miso[0].wready), 64'h0);
    next_cycle();
    s_mosi[0].aw.valid = 1'b0;
    settle();
    check("aft_m_wvalid",  64'(m_mosi.w.valid),   64'h1);
    check("aft_m_wdata",   64'(m_mosi.w.data),    64'hD0);
    check("aft_s0_wready", 64'(s_miso[0].wready), 64'h1);
    next_cycle();
    s_mosi[0].w.valid = 1'b0;

    // ---------------- AR lock and round robin ----------------
    m_miso.arready = 1'b0;
    s_mosi[1].ar.id = 6'h02; s_mosi[1].ar.addr = 32'h300; s_mosi[1].ar.len = 8'd7;
    s_mosi[1].ar.valid = 1'b1;
    settle();
    check("ar1_m_arvalid",  64'(m_mosi.ar.valid),    64'h1);
    check("ar1_m_arid",     64'(m_mosi.ar.id),       64'h22);
    check("ar1_m_araddr",   64'(m_mosi.ar.addr),     64'h300);
    check("ar1_m_arlen",    64'(m_mosi.ar.len),      64'h7);
    check("ar1_s1_arready", 64'(s_miso[1].arready),  64'h0);
    next_cycle();
    s_mosi[0].ar.id = 6'h07; s_mosi[0].ar.addr = 32'h400; s_mosi[0].ar.valid = 1'b1;
    settle();
    check("ar2_m_arid",     64'(m_mosi.ar.id),      64'h22);
    check("ar2_s0_arready", 64'(s_miso[0].arready), 64'h0);
    next_cycle(); settle();
    check("ar3_m_arid", 64'(m_mosi.ar.id), 64'h22);
    next_cycle();
    m_miso.arready = 1'b1;
    settle();
    check("ar4_m_arid",     64'(m_mosi.ar.id),      64'h22);
    check("ar4_s1_arready", 64'(s_miso[1].arready), 64'h1);
    check("ar4_s0_arready", 64'(s_miso[0].arready), 64'h0);
    next_cycle();
    s_mosi[1].ar.valid = 1'b0;
    settle();
    check("ar5_m_arid",     64'(m_mosi.ar.id),      64'h07);
    check("ar5_m_araddr",   64'(m_mosi.ar.addr),    64'h400);
    check("ar5_s0_arready", 64'(s_miso[0].arready), 64'h1);
    next_cycle();
    s_mosi[0].ar.valid = 1'b0;

    // ---------------- R routing ----------------
    m_miso.r.id = 6'h22; m_miso.r.data = 64'h55; m_miso.r.last = 1'b1; m_miso.r.valid = 1'b1;
    s_mosi[1].rready = 1'b1; s_mosi[0].rready = 1'b0;
    settle();
    check("r1_s1_rvalid", 64'(s_miso[1].r.valid), 64'h1);
    check("r1_s1_rid",    64'(s_miso[1].r.id),    64'h02);
    check("r1_s1_rlast",  64'(s_miso[1].r.last),  64'h1);
    check("r1_s1_rdata",  64'(s_miso[1].r.data),  64'h55);
    check("r1_s0_rvalid", 64'(s_miso[0].r.valid), 64'h0);
    check("r1_m_rready",  64'(m_mosi.rready),     64'h1);
    m_miso.r.id = 6'h07; m_miso.r.last = 1'b0;
    settle();
    check("r0_s0_rvalid", 64'(s_miso[0].r.valid), 64'h1);
    check("r0_s0_rid",    64'(s_miso[0].r.id),    64'h07);
    check("r0_s0_rlast",  64'(s_miso[0].r.last),  64'h0);
    check("r0_s1_rvalid", 64'(s_miso[1].r.valid), 64'h0);
    check("r0_m_rready",  64'(m_mosi.rready),     64'h0);
    m_miso.r.valid = 1'b0;

    // ---------------- asynchronous reset mid-burst ----------------
    m_miso.awready = 1'b1; m_miso.wready = 1'b0;
    s_mosi[0].aw.id = 6'h01; s_mosi[0].aw.valid = 1'b1;
    next_cycle();
    s_mosi[0].aw.valid = 1'b0;
    s_mosi[0].w.data = 64'hE0; s_mosi[0].w.last = 1'b0; s_mosi[0].w.valid = 1'b1;
    s_mosi[1].aw.id = 6'h04; s_mosi[1].aw.valid = 1'b1;
    m_miso.awready = 1'b0;
    settle();
    check("pre_m_wvalid",  64'(m_mosi.w.valid),  64'h1);
    check("pre_m_awvalid", 64'(m_mosi.aw.valid), 64'h1);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_m_wvalid",  64'(m_mosi.w.valid),  64'h0);
    check("arst_m_awvalid", 64'(m_mosi.aw.valid), 64'h0);
    check("arst_fifo_cnt",  64'(dut.fifo_cnt_q),  64'h0);
    s_mosi[1].aw.valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    next_cycle(); settle();
    check("post_m_wvalid",  64'(m_mosi.w.valid),   64'h0);
    check("post_s0_wready", 64'(s_miso[0].wready), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
